gen_addr_seq: RTL and testbench
===============================

Name: gen_addr_seq

Overview:
Parametrised address-sequence generator for the turbo/OFDM interleaver memory.
- On a start request it matches m_len against a table of supported link-ID block lengths.
- It then emits a contiguous address run: base address for that ID, for m_len addresses, with per-step stall control.
- Adds valid/first/last/done/error signalling, abort, and table-driven configuration.

Parameters:
ADDR_W, 16, address width
LEN_W, 13, m_len width
NUM_ID, 5, number of supported link IDs (table entries)
LEN_TABLE, {13'd1872,13'd432,13'd1056,13'd672,13'd288}, packed NUM_ID*LEN_W lengths; entry i at bits [i*LEN_W +: LEN_W]
BASE_TABLE, {16'd2448,16'd2016,16'd960,16'd288,16'd0}, packed NUM_ID*ADDR_W base addresses, same indexing

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
m_len  in  LEN_W  block length; sampled with start
step_en  in  1  advance enable; 0 holds the current address
abort  in  1  synchronous abort to IDLE
addr_out  out  ADDR_W  current address
addr_vld  out  1  addr_out valid
first  out  1  high with the first address of a run
last  out  1  high with the final address of a run
busy  out  1  high in LOAD and RUN
done  out  1  1-cycle pulse after the last address is accepted
err  out  1  1-cycle pulse on unsupported m_len
id_idx  out  3  matched table index, held for the run

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; internal counters 0.
- States:
  - IDLE: start=1 and m_len matches entry i → LOAD; latch base_r=BASE_TABLE[i], len_r=m_len, id_idx=i.
  - IDLE: start=1 with no match (including m_len=0) → err=1 next cycle; stay IDLE.
  - LOAD: 1 cycle; idx cleared to 0 → RUN.
  - RUN: addr_vld=1, addr_out=base_r+idx (mod 2^ADDR_W).
    - step_en=1 and idx!=len_r-1 → idx+1.
    - step_en=1 and idx==len_r-1 → DONE.
    - step_en=0 → hold addr_out, first and last.
  - DONE: done=1 for 1 cycle, addr_vld=0 → IDLE.
- Table match: first matching entry (lowest index) wins on duplicate lengths. Compare is combinational on m_len; all matching logic is registered before use.
- Latency: start sampled at edge t → LOAD during cycle t+1 → first valid address during cycle t+2. An address is consumed on an edge with addr_vld&step_en.
- first = (state==RUN)&&(idx==0). last = (state==RUN)&&(idx==len_r-1). Both are high together when len_r=1 (table-configurable only).
- busy = (state==LOAD)||(state==RUN).
- A start arriving in LOAD, RUN or DONE is ignored, with no err and no queueing. A start in the same cycle done is high is ignored; DONE→IDLE takes priority.
- abort=1 in any state → IDLE next edge.
  - addr_vld/first/last/busy deasserted.
  - done is not pulsed.
  - abort beats start in IDLE.
- addr_out holds its last value while addr_vld=0. Observers must qualify with addr_vld.
- idx width is LEN_W. base_r+idx is truncated to ADDR_W, with no error.

Test Plan:
- Reset: n_rst low mid-RUN → all outputs 0 immediately (asynchronous). After release, the block sits in IDLE.
- start, m_len=288, step_en=1 → addr_vld first at t+2.
  - addr_out 0..287; first at 0; last at 287; id_idx=0.
  - done one cycle after address 287.
- start, m_len=1056 → addr_out 960..2015, id_idx=2.
  - Drop step_en for 3 cycles at address 1000 → addr_out holds 1000 with addr_vld=1.
  - Total run length is 1056 accepted addresses.
- start, m_len=500 → err=1 one cycle at t+1; busy=0; no addr_vld.
  - Then m_len=1872 → addresses 2448..4319, done pulse.
- During a m_len=672 run (base 288): assert start with m_len=432 at address 400 → ignored, run completes at 959.
  - Then assert abort during a new run at address 2100 (m_len=432) → addr_vld=0 next cycle, no done.
  - A new start works afterwards.

Source files
------------

// File: rtl/gen_addr_seq_if.sv
// Request/address-stream bundle for the interleaver address generator.
// master drives requests and controls; slave produces the address stream.
interface gen_addr_seq_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 13
);
  logic              start;
  logic [LEN_W-1:0]  m_len;
  logic              step_en;
  logic              abort;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_vld;
  logic              first;
  logic              last;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        id_idx;

  modport master (
    output start, m_len, step_en, abort,
    input  addr_out, addr_vld, first, last, busy, done, err, id_idx
  );

  modport slave (
    input  start, m_len, step_en, abort,
    output addr_out, addr_vld, first, last, busy, done, err, id_idx
  );
endinterface

// File: rtl/gen_addr_seq.sv
// Address-sequence generator for the turbo/OFDM interleaver memory: maps a
// supported block length to a base address and emits a contiguous address run.
module gen_addr_seq #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 13,
  parameter int unsigned NUM_ID = 5,
  parameter logic [NUM_ID*LEN_W-1:0]  LEN_TABLE  = {13'd1872, 13'd432, 13'd1056, 13'd672, 13'd288},
  parameter logic [NUM_ID*ADDR_W-1:0] BASE_TABLE = {16'd2448, 16'd2016, 16'd960, 16'd288, 16'd0}
) (
  input  logic          clk,
  input  logic          n_rst,
  gen_addr_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] hold_q, hold_d;
  logic [2:0]        id_q, id_d;
  logic              err_q, err_d;

  logic              hit;
  logic [2:0]        hit_idx;
  logic [ADDR_W-1:0] hit_base;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  last_idx;

  // Lowest matching index wins; a zero length never matches.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int unsigned i = 0; i < NUM_ID; i++) begin
      if (!hit && (bus.m_len != '0) && (bus.m_len == LEN_TABLE[i*LEN_W +: LEN_W])) begin
        hit      = 1'b1;
        hit_idx  = 3'(i);
        hit_base = BASE_TABLE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign cur_addr = base_q + ADDR_W'(idx_q);
  assign last_idx = len_q - LEN_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    base_d  = base_q;
    id_d    = id_q;
    err_d   = 1'b0;
    hold_d  = hold_q;

    // Snapshot the live address so addr_out stays put once the run ends or aborts.
    if (state_q == RUN) hold_d = cur_addr;

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (hit) begin
              state_d = LOAD;
              base_d  = hit_base;
              len_d   = bus.m_len;
              id_d    = hit_idx;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        LOAD: begin
          idx_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          if (bus.step_en) begin
            if (idx_q == last_idx) state_d = DONE;
            else                   idx_d   = idx_q + LEN_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      hold_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      base_q  <= base_d;
      hold_q  <= hold_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign bus.addr_vld = (state_q == RUN);
  assign bus.addr_out = (state_q == RUN) ? cur_addr : hold_q;
  assign bus.first    = (state_q == RUN) && (idx_q == '0);
  assign bus.last     = (state_q == RUN) && (idx_q == last_idx);
  assign bus.busy     = (state_q == LOAD) || (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.err      = err_q;
  assign bus.id_idx   = id_q;

endmodule

// File: tb/tb_gen_addr_seq.sv
// Directed bench for gen_addr_seq: runs, stalls, bad lengths, ignored starts,
// abort and asynchronous reset, with hand-derived expected addresses.
module tb_gen_addr_seq;

  logic clk;
  logic n_rst;
  int   n_assert;
  int   n_fail;

  gen_addr_seq_if #(.ADDR_W(16), .LEN_W(13)) bus ();

  gen_addr_seq #(
    .ADDR_W (16),
    .LEN_W  (13),
    .NUM_ID (5)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a supported start; ends showing the first address of the run.
  task automatic start_req(input int len, input int id);
    bus.start = 1'b1;
    bus.m_len = 13'(len);
    tick();
    bus.start = 1'b0;
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_vld", 32'(bus.addr_vld), 32'd0);
    chk("load_id", 32'(bus.id_idx), 32'(id));
    chk("load_err", 32'(bus.err), 32'd0);
    tick();
  endtask

  // Check and consume run indices from..to with step_en high.
  task automatic walk(input int base, input int len, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      chk("addr", 32'(bus.addr_out), (base + i) & 32'hFFFF);
      chk("vld", 32'(bus.addr_vld), 32'd1);
      chk("first", 32'(bus.first), 32'(i == 0));
      chk("last", 32'(bus.last), 32'(i == len - 1));
      tick();
    end
  endtask

  task automatic finish_run();
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_vld", 32'(bus.addr_vld), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("done_clear", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    n_rst       = 1'b0;
    bus.start   = 1'b0;
    bus.m_len   = '0;
    bus.step_en = 1'b1;
    bus.abort   = 1'b0;
    #1;

    // Reset state
    chk("rst_addr", 32'(bus.addr_out), 32'd0);
    chk("rst_vld", 32'(bus.addr_vld), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_id", 32'(bus.id_idx), 32'd0);
    tick();
    n_rst = 1'b1;

    // Asynchronous reset mid-run (len 288, base 0)
    start_req(288, 0);
    walk(0, 288, 0, 149);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_addr", 32'(bus.addr_out), 32'd0);
    chk("arst_vld", 32'(bus.addr_vld), 32'd0);
    chk("arst_first", 32'(bus.first), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    n_rst = 1'b1;
    tick();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_vld", 32'(bus.addr_vld), 32'd0);

    // Full 288 run; a start during DONE is ignored
    start_req(288, 0);
    walk(0, 288, 0, 287);
    chk("done_pulse", 32'(bus.done), 32'd1);
    bus.start = 1'b1;
    bus.m_len = 13'd288;
    tick();
    bus.start = 1'b0;
    chk("done_start_ign_busy", 32'(bus.busy), 32'd0);
    chk("done_start_ign_done", 32'(bus.done), 32'd0);
    tick();
    chk("done_start_ign_busy2", 32'(bus.busy), 32'd0);

    // 1056 run (base 960) with 3-cycle stall at address 1000
    start_req(1056, 2);
    walk(960, 1056, 0, 39);
    bus.step_en = 1'b0;
    repeat (3) begin
      chk("stall_addr", 32'(bus.addr_out), 32'd1000);
      chk("stall_vld", 32'(bus.addr_vld), 32'd1);
      chk("stall_first", 32'(bus.first), 32'd0);
      tick();
    end
    bus.step_en = 1'b1;
    walk(960, 1056, 40, 1055);
    finish_run();
    chk("hold_after_done", 32'(bus.addr_out), 32'd2015);

    // Unsupported length
    bus.start = 1'b1;
    bus.m_len = 13'd500;
    tick();
    bus.start = 1'b0;
    chk("bad_err", 32'(bus.err), 32'd1);
    chk("bad_busy", 32'(bus.busy), 32'd0);
    chk("bad_vld", 32'(bus.addr_vld), 32'd0);
    tick();
    chk("bad_err_clear", 32'(bus.err), 32'd0);
    chk("bad_busy2", 32'(bus.busy), 32'd0);

    // Zero length is unsupported too
    bus.start = 1'b1;
    bus.m_len = 13'd0;
    tick();
    bus.start = 1'b0;
    chk("zero_err", 32'(bus.err), 32'd1);
    chk("zero_busy", 32'(bus.busy), 32'd0);
    tick();

    // 1872 run (base 2448)
    start_req(1872, 4);
    walk(2448, 1872, 0, 1871);
    finish_run();

    // 672 run (base 288); start with 432 at address 400 is ignored
    start_req(672, 1);
    walk(288, 672, 0, 111);
    bus.start = 1'b1;
    bus.m_len = 13'd432;
    walk(288, 672, 112, 112);
    bus.start = 1'b0;
    chk("ign_id", 32'(bus.id_idx), 32'd1);
    chk("ign_err", 32'(bus.err), 32'd0);
    walk(288, 672, 113, 671);
    finish_run();
    chk("ign_id_end", 32'(bus.id_idx), 32'd1);

    // 432 run (base 2016) aborted at address 2100
    start_req(432, 3);
    walk(2016, 432, 0, 83);
    chk("pre_abort_addr", 32'(bus.addr_out), 32'd2100);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_vld", 32'(bus.addr_vld), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_first", 32'(bus.first), 32'd0);
    chk("abort_last", 32'(bus.last), 32'd0);
    chk("abort_hold", 32'(bus.addr_out), 32'd2100);
    tick();
    chk("abort_done2", 32'(bus.done), 32'd0);
    chk("abort_vld2", 32'(bus.addr_vld), 32'd0);

    // Abort beats start in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.m_len = 13'd288;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_busy", 32'(bus.busy), 32'd0);
    chk("abort_start_err", 32'(bus.err), 32'd0);
    chk("abort_start_id", 32'(bus.id_idx), 32'd3);
    tick();
    chk("abort_start_vld", 32'(bus.addr_vld), 32'd0);

    // New start after abort
    start_req(288, 0);
    walk(0, 288, 0, 287);
    finish_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
